// File: rtl/spike_gen_pkg.sv
// spike_gen_pkg: shared host codes, FSM states and programming field bundle for the spike generator front end
package spike_gen_pkg;
    typedef enum logic [1:0] {PROG, GENS_USED, GEN_EN, ABORT} host_code_t;
    typedef enum logic {COLLECT, EMIT} state_t;
    localparam int NChunks = 4;
    typedef struct packed {
        logic [15:0] gen_idx;
        logic [15:0] period;
        logic [15:0] ticks;
        logic [15:0] tag;
    } prog_fields_t;
    function automatic logic [15:0] zext(input logic [15:0] d, input int w);
        return d & 16'((17'(1) << w) - 17'(1));
    endfunction
endpackage

// File: rtl/spike_gen_conf_regs.sv
// spike_gen_conf_regs: gens_used / gens_en conf registers and the saturating drop counter
module spike_gen_conf_regs
    import spike_gen_pkg::*;
#(
    parameter int Ngens = 8,
    parameter int Nerr = 8,
    localparam int NgenIdx = $clog2(Ngens)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  host_code_t         code,
    input  logic [15:0]        data,
    input  logic               drop,
    output logic [NgenIdx:0]   gens_used,
    output logic [Ngens-1:0]   gens_en,
    output logic [Nerr-1:0]    err_ct
);
    logic bad_en;
    assign bad_en = we && code == GEN_EN && data[14:0] >= 15'(Ngens);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gens_used <= '0;
            gens_en <= '0;
            err_ct <= '0;
        end else begin
            if (we && code == GENS_USED)
                gens_used <= data >= 16'(Ngens) ? (NgenIdx+1)'(Ngens) : data[NgenIdx:0];
            if (we && code == GEN_EN && !bad_en)
                gens_en[data[NgenIdx-1:0]] <= data[15];
            if ((drop || bad_en) && err_ct != '1)
                err_ct <= err_ct + Nerr'(1);
        end
    end
endmodule

// File: rtl/spike_gen_prog_assembler.sv
// spike_gen_prog_assembler: assembles 4 PROG chunks into one generator programming transaction and applies conf writes
module spike_gen_prog_assembler
    import spike_gen_pkg::*;
#(
    parameter int Ngens = 8,
    parameter int Nperiod = 16,
    parameter int Ntag = 11,
    parameter int Nerr = 8,
    localparam int NgenIdx = $clog2(Ngens)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_v,
    output logic               in_a,
    input  logic [17:0]        in_d,
    output logic               prog_v,
    input  logic               prog_a,
    output logic [NgenIdx-1:0] prog_gen_idx,
    output logic [Nperiod-1:0] prog_period,
    output logic [Nperiod-1:0] prog_ticks,
    output logic [Ntag-1:0]    prog_tag,
    output logic [NgenIdx:0]   gens_used,
    output logic [Ngens-1:0]   gens_en,
    output logic [Nerr-1:0]    err_ct
);
    state_t state, state_nx;
    logic [1:0] chunk_ct, chunk_nx;
    prog_fields_t f, f_nx;
    logic xfer, prog_w, last, drop;
    host_code_t code;
    logic [15:0] data;
    assign code = host_code_t'(in_d[17:16]);
    assign data = in_d[15:0];
    assign xfer = in_v && in_a;
    assign in_a = state == COLLECT;
    assign prog_v = state == EMIT;
    // gen_idx keeps the full data word so out-of-range indices can be detected and dropped
    assign prog_gen_idx = NgenIdx'(f.gen_idx);
    assign prog_period = Nperiod'(f.period);
    assign prog_ticks = Nperiod'(f.ticks);
    assign prog_tag = Ntag'(f.tag);
    always_comb begin
        prog_w = xfer && code == PROG;
        last = chunk_ct == 2'(NChunks - 1);
        drop = prog_w && last && f.gen_idx >= 16'(Ngens);
        f_nx.gen_idx = prog_w && chunk_ct == 2'd0 ? data : f.gen_idx;
        f_nx.period = prog_w && chunk_ct == 2'd1 ? zext(data, Nperiod) : f.period;
        f_nx.ticks = prog_w && chunk_ct == 2'd2 ? zext(data, Nperiod) : f.ticks;
        f_nx.tag = prog_w && chunk_ct == 2'd3 ? zext(data, Ntag) : f.tag;
        chunk_nx = xfer && code == ABORT ? 2'd0 : prog_w ? chunk_ct + 2'd1 : chunk_ct;
        state_nx = state == EMIT ? (prog_a ? COLLECT : EMIT) : (prog_w && last && !drop ? EMIT : COLLECT);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
            chunk_ct <= '0;
            f <= '0;
        end else begin
            state <= state_nx;
            chunk_ct <= chunk_nx;
            f <= f_nx;
        end
    end
    spike_gen_conf_regs #(.Ngens(Ngens), .Nerr(Nerr)) u_conf (
        .clk(clk),
        .reset(reset),
        .we(xfer),
        .code(code),
        .data(data),
        .drop(drop),
        .gens_used(gens_used),
        .gens_en(gens_en),
        .err_ct(err_ct)
    );
endmodule

// File: tb/tb_spike_gen_prog_assembler.sv
// tb_spike_gen_prog_assembler: scoreboard bench for the PROG chunk assembler and conf writes
module tb_spike_gen_prog_assembler;
    import spike_gen_pkg::*;
    logic clk = 0, reset = 1, in_v = 0, in_a, prog_v, prog_a = 1;
    logic [17:0] in_d = '0;
    logic [2:0] prog_gen_idx;
    logic [15:0] prog_period, prog_ticks;
    logic [10:0] prog_tag;
    logic [3:0] gens_used;
    logic [7:0] gens_en, err_ct;
    prog_fields_t exp_q[$];
    int n_vec = 0, n_err = 0, pv_cycles = 0;
    logic [7:0] exp_err = 0;

    spike_gen_prog_assembler dut (
        .clk(clk), .reset(reset), .in_v(in_v), .in_a(in_a), .in_d(in_d),
        .prog_v(prog_v), .prog_a(prog_a), .prog_gen_idx(prog_gen_idx),
        .prog_period(prog_period), .prog_ticks(prog_ticks), .prog_tag(prog_tag),
        .gens_used(gens_used), .gens_en(gens_en), .err_ct(err_ct)
    );

    always #5 clk = ~clk;

    // Transfer is seen at the negedge before the accepting posedge
    always @(negedge clk) begin
        if (prog_v) pv_cycles++;
        if (prog_v && prog_a) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL prog_unexpected got {%0d,%0d,%0d,%0d} expected none", prog_gen_idx, prog_period, prog_ticks, prog_tag);
            end else begin
                prog_fields_t e;
                e = exp_q.pop_front();
                if ({16'(prog_gen_idx), prog_period, prog_ticks, 16'(prog_tag)} !== {e.gen_idx, e.period, e.ticks, e.tag}) begin
                    n_err++;
                    $display("FAIL prog_fields got {%0d,%0d,%0d,%0d} expected {%0d,%0d,%0d,%0d}",
                             prog_gen_idx, prog_period, prog_ticks, prog_tag, e.gen_idx, e.period, e.ticks, e.tag);
                end
            end
        end
    end

    task automatic send(input logic [1:0] c, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        in_v = 1;
        in_d = {c, d};
        while (!in_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout in_a=%0b expected 1", in_a);
        end
        @(posedge clk);
        #1 in_v = 0;
    endtask

    task automatic send_prog(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d, input bit expect_it);
        prog_fields_t e;
        e.gen_idx = a; e.period = b; e.ticks = c; e.tag = d;
        if (expect_it) exp_q.push_back(e);
        send(0, a); send(0, b); send(0, c); send(0, d);
    endtask

    task automatic check_drained(input string name);
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s pending=%0d expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec++;
        if ({in_a, prog_v, prog_gen_idx, prog_period, prog_ticks, prog_tag, gens_used, gens_en, err_ct} !== {1'b1, 67'b0}) begin
            n_err++;
            $display("FAIL reset_state in_a=%0b prog_v=%0b idx=%0d per=%0d tk=%0d tag=%0d gu=%0d en=%0h err=%0d expected in_a=1 rest 0",
                     in_a, prog_v, prog_gen_idx, prog_period, prog_ticks, prog_tag, gens_used, gens_en, err_ct);
        end
        reset = 0;
    endtask

    task automatic test_back_to_back;
        prog_a = 1;
        pv_cycles = 0;
        send_prog(0, 2, 0, 512, 1);
        check_drained("b2b_drain");
        n_vec++;
        if (pv_cycles != 1) begin
            n_err++;
            $display("FAIL b2b_prog_v_cycles got %0d expected 1", pv_cycles);
        end
    endtask

    task automatic test_stall;
        prog_a = 0;
        send_prog(1, 4, 2, 513, 1);
        repeat (10) begin
            @(negedge clk);
            n_vec++;
            if ({prog_v, in_a, prog_gen_idx, prog_period, prog_ticks, prog_tag} !== {1'b1, 1'b0, 3'd1, 16'd4, 16'd2, 11'd513}) begin
                n_err++;
                $display("FAIL stall_hold v=%0b a=%0b {%0d,%0d,%0d,%0d} expected v=1 a=0 {1,4,2,513}",
                         prog_v, in_a, prog_gen_idx, prog_period, prog_ticks, prog_tag);
            end
        end
        @(posedge clk);
        #1 prog_a = 1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({in_a, prog_v} !== 2'b10) begin
            n_err++;
            $display("FAIL stall_release in_a=%0b prog_v=%0b expected in_a=1 prog_v=0", in_a, prog_v);
        end
        check_drained("stall_drain");
    endtask

    task automatic test_conf;
        send(1, 2);
        n_vec++;
        if (gens_used !== 4'd2) begin n_err++; $display("FAIL gens_used_2 got %0d expected 2", gens_used); end
        send(2, 16'h8000);
        send(2, 16'h8001);
        n_vec++;
        if (gens_en !== 8'h03) begin n_err++; $display("FAIL gens_en_set got %0h expected 3", gens_en); end
        send(2, 16'h0000);
        n_vec++;
        if (gens_en !== 8'h02) begin n_err++; $display("FAIL gens_en_clr got %0h expected 2", gens_en); end
        send(1, 100);
        n_vec++;
        if (gens_used !== 4'd8) begin n_err++; $display("FAIL gens_used_sat got %0d expected 8", gens_used); end
        send(2, 16'h8009);
        exp_err++;
        n_vec++;
        if ({gens_en, err_ct} !== {8'h02, exp_err}) begin
            n_err++;
            $display("FAIL gen_en_bad_idx en=%0h err=%0d expected en=2 err=%0d", gens_en, err_ct, exp_err);
        end
    endtask

    task automatic test_interleave;
        prog_fields_t e;
        e.gen_idx = 5; e.period = 7; e.ticks = 1; e.tag = 9;
        exp_q.push_back(e);
        send(0, 5);
        send(2, 16'h8003);
        n_vec++;
        if (gens_en !== 8'h0A) begin n_err++; $display("FAIL interleave_en got %0h expected a", gens_en); end
        send(0, 7); send(0, 1); send(0, 9);
        check_drained("interleave_drain");
    endtask

    task automatic test_abort_drop;
        send(0, 0); send(0, 2); send(3, 0);
        send_prog(3, 4, 5, 6, 1);
        check_drained("abort_drain");
        pv_cycles = 0;
        send_prog(9, 1, 1, 1, 0);
        exp_err++;
        repeat (3) @(negedge clk);
        n_vec++;
        if (pv_cycles != 0 || err_ct !== exp_err) begin
            n_err++;
            $display("FAIL drop_idx9 prog_v_cycles=%0d err=%0d expected 0 and %0d", pv_cycles, err_ct, exp_err);
        end
    endtask

    task automatic test_reset_mid;
        send(0, 1); send(0, 2);
        @(negedge clk); reset = 1;
        @(negedge clk);
        n_vec++;
        if ({prog_v, in_a, gens_en, err_ct} !== {2'b01, 16'h0}) begin
            n_err++;
            $display("FAIL reset_collect v=%0b a=%0b en=%0h err=%0d expected 0 1 0 0", prog_v, in_a, gens_en, err_ct);
        end
        reset = 0;
        prog_a = 0;
        send_prog(6, 6, 6, 6, 0);
        @(negedge clk);
        n_vec++;
        if (prog_v !== 1'b1) begin n_err++; $display("FAIL reset_emit_pre prog_v=%0b expected 1", prog_v); end
        reset = 1;
        @(negedge clk);
        n_vec++;
        if ({prog_v, in_a, prog_tag} !== {2'b01, 11'd0}) begin
            n_err++;
            $display("FAIL reset_emit v=%0b a=%0b tag=%0d expected 0 1 0", prog_v, in_a, prog_tag);
        end
        reset = 0;
        prog_a = 1;
        send_prog(2, 3, 4, 5, 1);
        check_drained("post_reset_drain");
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_stall;
        test_conf;
        test_interleave;
        test_abort_drop;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
